bridge_reg_bank: RTL and testbench
==================================

Name: bridge_reg_bank

Overview:
- Bridge-side register bank sitting directly downstream of the bridge clock-domain crossing, in the core clock domain.
- Consumes the core-side bridge strobes (addr, wr_data, wr, rd) and produces rd_data for return across the crossing.
- Decodes a word-aligned address window into control registers (bridge-writable, driven to core logic) and status registers (core-driven, read-only).
- Generates one-cycle change strobes for core logic on every control write.

Parameters:
- base_addr, 32'h0000_0000, window base; must be aligned to num_regs*4 rounded up to a power of two.
- num_ctrl, 4, number of control registers (1..16).
- num_status, 4, number of status registers (0..16).
- ctrl_reset_value, 32'h0000_0000, reset value of every control register.

Ports:
- clk  in  1  core clock; also the core-side clock of the bridge crossing.
- reset  in  1  asynchronous, active-high reset.
- bridge_addr  in  32  byte address, valid while bridge_wr or bridge_rd is high.
- bridge_wr  in  1  single-cycle write strobe.
- bridge_rd  in  1  single-cycle read strobe.
- bridge_wr_data  in  32  write data.
- bridge_rd_data  out  32  registered read data; holds its value between reads.
- rd_hit  out  1  one-cycle pulse: the preceding read decoded inside the window.
- ctrl  out  num_ctrl*32  control register contents; register i occupies bits [32i+31:32i].
- ctrl_changed  out  num_ctrl  one-cycle pulse per register written.
- status  in  num_status*32  status values, packed in the same way as ctrl.

Behaviour:
- Decode:
  - Offset = bridge_addr - base_addr. Hit when offset < (num_ctrl+num_status)*4.
  - Index = offset[31:2]; bridge_addr[1:0] is ignored.
  - Indices 0..num_ctrl-1 are control registers; num_ctrl..num_ctrl+num_status-1 are status registers.
- Write:
  - bridge_wr with a hit on a control index loads ctrl[index] at the clock edge.
  - ctrl_changed[index] is high for exactly the next cycle, aligned with the new ctrl value.
  - Writes to status indices and to addresses outside the window are dropped; no strobe is generated.
- Read:
  - bridge_rd with a hit: bridge_rd_data is updated at the clock edge, so it is valid the cycle after the strobe (1-cycle latency). rd_hit pulses in that same cycle.
  - Miss: bridge_rd_data holds its previous value and rd_hit stays 0.
  - Rationale: the downstream return crossing forwards only on change, so rd_data must never glitch or return to 0 between reads.
- Simultaneous wr and rd on the same cycle (not produced by the crossing, but defined):
  - The write is applied.
  - The read returns the pre-write value of the addressed register.
- Back-to-back strobes on consecutive cycles are each handled independently. Pulses on ctrl_changed and rd_hit may therefore be high on consecutive cycles.
- Reset (asynchronous assert, synchronous release):
  - ctrl = ctrl_reset_value for all registers.
  - bridge_rd_data = 0, rd_hit = 0, ctrl_changed = 0.
  - A reset asserted mid-operation discards any in-flight strobe; no ctrl_changed pulse follows reset release.
- Elaboration:
  - A static assertion rejects num_ctrl = 0 and num_ctrl+num_status > 32.
  - A static assertion rejects a base_addr misaligned to the window size.

Optional Feature:
- BRIDGE_REG_BANK_STATUS_SYNC_EN
- Defined:
  - Each status word passes through a two-flop synchronizer before the read mux.
  - Status read latency relative to the status input becomes 2 extra cycles.
  - Synchronizer flops reset to 0.
  - For status sources in unrelated clock domains that are quasi-static.
- Undefined: status feeds the read mux directly (same-clock sources only); control behaviour is identical in both builds.

Test Plan:
- Reset with ctrl_reset_value=32'hA5A5_0000, then read base+0 -> bridge_rd_data=32'hA5A5_0000 one cycle after bridge_rd, rd_hit pulse of 1 cycle, ctrl_changed=0.
- Write 32'h1234_5678 to base+4 -> ctrl[1]=32'h1234_5678 next cycle, ctrl_changed=4'b0010 for exactly one cycle; read base+4 returns 32'h1234_5678.
- status[2]=32'hCAFE_F00D (num_ctrl=4, index 6), read base+24 -> 32'hCAFE_F00D; write 32'hFFFF_FFFF to base+24 -> no ctrl change, no strobe, a subsequent read still returns 32'hCAFE_F00D.
- Read base+24 (returns 32'hCAFE_F00D), then read base+64 (miss) -> bridge_rd_data stays 32'hCAFE_F00D, rd_hit=0; read base+1 -> decodes as index 0.
- Same-cycle wr 32'h0000_0001 and rd at base+0, with ctrl[0]=32'h0 beforehand -> bridge_rd_data=32'h0, ctrl[0]=32'h1; then assert reset mid back-to-back writes -> all outputs return to reset values asynchronously, no strobe after release.
- With BRIDGE_REG_BANK_STATUS_SYNC_EN: change status[0] from 32'h0 to 32'h5, read on the same cycle the input changes -> returns 32'h0; read 3 cycles later -> returns 32'h5.

Source files
------------

// File: rtl/bridge_reg_bank.sv
// Core-side register bank behind the bridge crossing: control registers with change strobes,
// read-only status registers, registered read data. Optional macro: BRIDGE_REG_BANK_STATUS_SYNC_EN.
module bridge_reg_bank #(
    parameter logic [31:0] base_addr        = 32'h0000_0000,
    parameter int          num_ctrl         = 4,
    parameter int          num_status       = 4,
    parameter logic [31:0] ctrl_reset_value = 32'h0000_0000,
    localparam int         STATUS_W         = (num_status > 0) ? num_status * 32 : 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             bridge_addr,
    input  logic                    bridge_wr,
    input  logic                    bridge_rd,
    input  logic [31:0]             bridge_wr_data,
    output logic [31:0]             bridge_rd_data,
    output logic                    rd_hit,
    output logic [num_ctrl*32-1:0]  ctrl,
    output logic [num_ctrl-1:0]     ctrl_changed,
    input  logic [STATUS_W-1:0]     status
);

    localparam int NUM_REGS  = num_ctrl + num_status;
    localparam int WIN_BYTES = NUM_REGS * 4;
    localparam int WIN_BITS  = $clog2(WIN_BYTES);
    localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int MUX_DEPTH = 1 << IDX_W;
    localparam logic [31:0] WIN_MASK = (32'd1 << WIN_BITS) - 32'd1;

    if ((num_ctrl < 1) || (NUM_REGS > 32)) begin : g_bad_count
        $error("bridge_reg_bank: num_ctrl must be >= 1 and num_ctrl+num_status <= 32");
    end

    if ((base_addr & WIN_MASK) != 32'd0) begin : g_bad_base
        $error("bridge_reg_bank: base_addr not aligned to the decode window");
    end

    logic [31:0]          offset_s;
    logic                 hit_s;
    logic [IDX_W-1:0]     idx_s;
    logic [num_ctrl-1:0]  wr_sel_s;
    logic [31:0]          mux_words_s [MUX_DEPTH];
    logic [STATUS_W-1:0]  status_view_s;

    logic [31:0]          ctrl_q [num_ctrl];
    logic [31:0]          ctrl_d [num_ctrl];
    logic [num_ctrl-1:0]  ctrl_changed_q;
    logic [num_ctrl-1:0]  ctrl_changed_d;
    logic [31:0]          rd_data_q;
    logic [31:0]          rd_data_d;
    logic                 rd_hit_q;
    logic                 rd_hit_d;

    // Wrapping subtraction: addresses below the base produce a huge offset and miss.
    assign offset_s = bridge_addr - base_addr;
    assign hit_s    = (offset_s < 32'(WIN_BYTES));
    assign idx_s    = offset_s[IDX_W+1:2];

`ifdef BRIDGE_REG_BANK_STATUS_SYNC_EN
    logic [STATUS_W-1:0] status_meta_q;
    logic [STATUS_W-1:0] status_sync_q;

    // Two-flop synchronizer for quasi-static status from foreign clock domains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_meta_q <= '0;
            status_sync_q <= '0;
        end else begin
            status_meta_q <= status;
            status_sync_q <= status_meta_q;
        end
    end

    assign status_view_s = status_sync_q;
`else
    assign status_view_s = status;
`endif

    for (genvar i = 0; i < MUX_DEPTH; i++) begin : g_mux
        if (i < num_ctrl) begin : g_ctrl_word
            assign mux_words_s[i] = ctrl_q[i];
        end else if (i < NUM_REGS) begin : g_status_word
            assign mux_words_s[i] = status_view_s[(i-num_ctrl)*32 +: 32];
        end else begin : g_empty_word
            assign mux_words_s[i] = 32'h0000_0000;
        end
    end

    for (genvar i = 0; i < num_ctrl; i++) begin : g_ctrl
        assign wr_sel_s[i]        = bridge_wr && hit_s && (idx_s == IDX_W'(i));
        assign ctrl[i*32 +: 32]   = ctrl_q[i];
    end

    // Next-state for control registers and their change strobes.
    always_comb begin
        for (int i = 0; i < num_ctrl; i++) begin
            if (wr_sel_s[i]) begin
                ctrl_d[i] = bridge_wr_data;
            end else begin
                ctrl_d[i] = ctrl_q[i];
            end
        end
        ctrl_changed_d = wr_sel_s;
    end

    // Read data holds on a miss so the return crossing never sees a spurious change.
    always_comb begin
        rd_hit_d = bridge_rd && hit_s;
        if (rd_hit_d) begin
            rd_data_d = mux_words_s[idx_s];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State registers; reset drops any strobe that was in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < num_ctrl; i++) begin
                ctrl_q[i] <= ctrl_reset_value;
            end
            ctrl_changed_q <= '0;
            rd_data_q      <= 32'h0000_0000;
            rd_hit_q       <= 1'b0;
        end else begin
            for (int i = 0; i < num_ctrl; i++) begin
                ctrl_q[i] <= ctrl_d[i];
            end
            ctrl_changed_q <= ctrl_changed_d;
            rd_data_q      <= rd_data_d;
            rd_hit_q       <= rd_hit_d;
        end
    end

    assign bridge_rd_data = rd_data_q;
    assign rd_hit         = rd_hit_q;
    assign ctrl_changed   = ctrl_changed_q;

endmodule

// File: tb/tb_bridge_reg_bank.sv
// Self-checking bench for bridge_reg_bank: directed scenarios plus randomized traffic
// checked against a word-array model of the register map.
module tb_bridge_reg_bank;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] RST  = 32'hA5A5_0000;

    logic         clk;
    logic         reset;
    logic [31:0]  bridge_addr;
    logic         bridge_wr;
    logic         bridge_rd;
    logic [31:0]  bridge_wr_data;
    logic [31:0]  bridge_rd_data;
    logic         rd_hit;
    logic [127:0] ctrl;
    logic [3:0]   ctrl_changed;
    logic [127:0] status;
    logic [31:0]  status_v [4];

    int tests;
    int fails;

    logic [31:0] m_ctrl [4];
    logic [31:0] m_rd;
    logic        m_hit;
    logic [3:0]  m_chg;

    assign status = {status_v[3], status_v[2], status_v[1], status_v[0]};

    bridge_reg_bank #(
        .base_addr        (BASE),
        .num_ctrl         (4),
        .num_status       (4),
        .ctrl_reset_value (RST)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bridge_addr    (bridge_addr),
        .bridge_wr      (bridge_wr),
        .bridge_rd      (bridge_rd),
        .bridge_wr_data (bridge_wr_data),
        .bridge_rd_data (bridge_rd_data),
        .rd_hit         (rd_hit),
        .ctrl           (ctrl),
        .ctrl_changed   (ctrl_changed),
        .status         (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pack_ctrl();
        return {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]};
    endfunction

    // Register map: 8 words starting at BASE, first four control, last four status.
    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w;
        w = int'((a - BASE) >> 2);
        if (w < 4) return m_ctrl[w];
        return status_v[w-4];
    endfunction

    task automatic step(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        off = a - BASE;
        bridge_wr      = wr;
        bridge_rd      = rd;
        bridge_addr    = a;
        bridge_wr_data = d;
        m_hit = rd && (off < 32'd32);
        if (m_hit) m_rd = model_read(a);
        m_chg = 4'b0000;
        if (wr && (off < 32'd16)) begin
            m_ctrl[off[3:2]] = d;
            m_chg[off[3:2]]  = 1'b1;
        end
        @(posedge clk);
        #1;
        bridge_wr = 1'b0;
        bridge_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic test_reset();
        tests++; if (bridge_rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data: got %h expected %h", bridge_rd_data, 32'h0); end
        tests++; if (rd_hit !== 1'b0) begin fails++; $display("FAIL reset_rd_hit: got %b expected 0", rd_hit); end
        tests++; if (ctrl_changed !== 4'b0) begin fails++; $display("FAIL reset_changed: got %b expected 0000", ctrl_changed); end
        tests++; if (ctrl !== {4{RST}}) begin fails++; $display("FAIL reset_ctrl: got %h expected %h", ctrl, {4{RST}}); end
        step(1'b0, 1'b1, BASE, 32'h0);
        tests++; if (bridge_rd_data !== 32'hA5A5_0000) begin fails++; $display("FAIL reset_read_data: got %h expected %h", bridge_rd_data, 32'hA5A5_0000); end
        tests++; if (rd_hit !== 1'b1) begin fails++; $display("FAIL reset_read_hit: got %b expected 1", rd_hit); end
        tests++; if (ctrl_changed !== 4'b0) begin fails++; $display("FAIL reset_read_changed: got %b expected 0000", ctrl_changed); end
        idle(1);
        tests++; if (rd_hit !== 1'b0) begin fails++; $display("FAIL reset_hit_pulse: got %b expected 0", rd_hit); end
        tests++; if (bridge_rd_data !== 32'hA5A5_0000) begin fails++; $display("FAIL reset_read_hold: got %h expected %h", bridge_rd_data, 32'hA5A5_0000); end
    endtask

    task automatic test_write();
        step(1'b1, 1'b0, BASE + 32'd4, 32'h1234_5678);
        tests++; if (ctrl[63:32] !== 32'h1234_5678) begin fails++; $display("FAIL write_ctrl1: got %h expected %h", ctrl[63:32], 32'h1234_5678); end
        tests++; if (ctrl_changed !== 4'b0010) begin fails++; $display("FAIL write_strobe: got %b expected 0010", ctrl_changed); end
        idle(1);
        tests++; if (ctrl_changed !== 4'b0000) begin fails++; $display("FAIL write_strobe_len: got %b expected 0000", ctrl_changed); end
        step(1'b0, 1'b1, BASE + 32'd4, 32'h0);
        tests++; if (bridge_rd_data !== 32'h1234_5678) begin fails++; $display("FAIL write_readback: got %h expected %h", bridge_rd_data, 32'h1234_5678); end
    endtask

    task automatic test_status();
        status_v[2] = 32'hCAFE_F00D;
        idle(3);
        step(1'b0, 1'b1, BASE + 32'd24, 32'h0);
        tests++; if (bridge_rd_data !== 32'hCAFE_F00D) begin fails++; $display("FAIL status_read: got %h expected %h", bridge_rd_data, 32'hCAFE_F00D); end
        step(1'b1, 1'b0, BASE + 32'd24, 32'hFFFF_FFFF);
        tests++; if (ctrl_changed !== 4'b0000) begin fails++; $display("FAIL status_wr_strobe: got %b expected 0000", ctrl_changed); end
        tests++; if (ctrl !== pack_ctrl()) begin fails++; $display("FAIL status_wr_ctrl: got %h expected %h", ctrl, pack_ctrl()); end
        step(1'b0, 1'b1, BASE + 32'd24, 32'h0);
        tests++; if (bridge_rd_data !== 32'hCAFE_F00D) begin fails++; $display("FAIL status_reread: got %h expected %h", bridge_rd_data, 32'hCAFE_F00D); end
    endtask

    task automatic test_miss();
        step(1'b0, 1'b1, BASE + 32'd24, 32'h0);
        step(1'b0, 1'b1, BASE + 32'd64, 32'h0);
        tests++; if (bridge_rd_data !== 32'hCAFE_F00D) begin fails++; $display("FAIL miss_hold: got %h expected %h", bridge_rd_data, 32'hCAFE_F00D); end
        tests++; if (rd_hit !== 1'b0) begin fails++; $display("FAIL miss_hit: got %b expected 0", rd_hit); end
        step(1'b0, 1'b1, BASE - 32'd4, 32'h0);
        tests++; if (rd_hit !== 1'b0) begin fails++; $display("FAIL below_base_hit: got %b expected 0", rd_hit); end
        step(1'b0, 1'b1, BASE + 32'd1, 32'h0);
        tests++; if (bridge_rd_data !== RST) begin fails++; $display("FAIL unaligned_read: got %h expected %h", bridge_rd_data, RST); end
        tests++; if (rd_hit !== 1'b1) begin fails++; $display("FAIL unaligned_hit: got %b expected 1", rd_hit); end
    endtask

    task automatic test_same_cycle();
        step(1'b1, 1'b0, BASE, 32'h0000_0000);
        step(1'b1, 1'b1, BASE, 32'h0000_0001);
        tests++; if (bridge_rd_data !== 32'h0) begin fails++; $display("FAIL rw_read_old: got %h expected %h", bridge_rd_data, 32'h0); end
        tests++; if (ctrl[31:0] !== 32'h1) begin fails++; $display("FAIL rw_ctrl0: got %h expected %h", ctrl[31:0], 32'h1); end
        tests++; if (ctrl_changed !== 4'b0001) begin fails++; $display("FAIL rw_strobe: got %b expected 0001", ctrl_changed); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, BASE + 32'd8, 32'h0BAD_0002);
        tests++; if (ctrl_changed !== 4'b0100) begin fails++; $display("FAIL b2b_strobe2: got %b expected 0100", ctrl_changed); end
        step(1'b1, 1'b0, BASE + 32'd12, 32'h0BAD_0003);
        tests++; if (ctrl_changed !== 4'b1000) begin fails++; $display("FAIL b2b_strobe3: got %b expected 1000", ctrl_changed); end
        step(1'b0, 1'b1, BASE + 32'd8, 32'h0);
        tests++; if (bridge_rd_data !== 32'h0BAD_0002 || rd_hit !== 1'b1) begin fails++; $display("FAIL b2b_read2: got %h/%b expected %h/1", bridge_rd_data, rd_hit, 32'h0BAD_0002); end
        step(1'b0, 1'b1, BASE + 32'd12, 32'h0);
        tests++; if (bridge_rd_data !== 32'h0BAD_0003 || rd_hit !== 1'b1) begin fails++; $display("FAIL b2b_read3: got %h/%b expected %h/1", bridge_rd_data, rd_hit, 32'h0BAD_0003); end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, BASE + 32'd24, 32'h0);
        step(1'b1, 1'b0, BASE + 32'd8, 32'h1111_1111);
        bridge_wr      = 1'b1;
        bridge_addr    = BASE + 32'd12;
        bridge_wr_data = 32'h2222_2222;
        #2 reset = 1'b1;
        #1;
        tests++; if (ctrl !== {4{RST}}) begin fails++; $display("FAIL async_ctrl: got %h expected %h", ctrl, {4{RST}}); end
        tests++; if (ctrl_changed !== 4'b0) begin fails++; $display("FAIL async_changed: got %b expected 0000", ctrl_changed); end
        tests++; if (bridge_rd_data !== 32'h0) begin fails++; $display("FAIL async_rd_data: got %h expected %h", bridge_rd_data, 32'h0); end
        @(posedge clk);
        #1;
        bridge_wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (ctrl_changed !== 4'b0) begin fails++; $display("FAIL release_changed: got %b expected 0000", ctrl_changed); end
        tests++; if (ctrl !== {4{RST}}) begin fails++; $display("FAIL release_ctrl: got %h expected %h", ctrl, {4{RST}}); end
        for (int i = 0; i < 4; i++) m_ctrl[i] = RST;
        m_rd = 32'h0;
        idle(1);
        tests++; if (ctrl_changed !== 4'b0 || rd_hit !== 1'b0) begin fails++; $display("FAIL release_quiet: got %b/%b expected 0000/0", ctrl_changed, rd_hit); end
    endtask

    task automatic test_status_timing();
        status_v[0] = 32'h0;
        idle(3);
        bridge_rd   = 1'b1;
        bridge_addr = BASE + 32'd16;
        status_v[0] = 32'h5;
        @(posedge clk);
        #1;
        bridge_rd = 1'b0;
`ifdef BRIDGE_REG_BANK_STATUS_SYNC_EN
        tests++; if (bridge_rd_data !== 32'h0) begin fails++; $display("FAIL sync_old_value: got %h expected %h", bridge_rd_data, 32'h0); end
`else
        tests++; if (bridge_rd_data !== 32'h5) begin fails++; $display("FAIL direct_new_value: got %h expected %h", bridge_rd_data, 32'h5); end
`endif
        idle(2);
        step(1'b0, 1'b1, BASE + 32'd16, 32'h0);
        tests++; if (bridge_rd_data !== 32'h5) begin fails++; $display("FAIL status_settled: got %h expected %h", bridge_rd_data, 32'h5); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 4; i++) status_v[i] = $urandom;
        idle(3);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, 47));
            else a = $urandom;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            tests++; if (bridge_rd_data !== m_rd) begin fails++; $display("FAIL rand_rd_data[%0d]: got %h expected %h", n, bridge_rd_data, m_rd); end
            tests++; if (rd_hit !== m_hit) begin fails++; $display("FAIL rand_rd_hit[%0d]: got %b expected %b", n, rd_hit, m_hit); end
            tests++; if (ctrl_changed !== m_chg) begin fails++; $display("FAIL rand_changed[%0d]: got %b expected %b", n, ctrl_changed, m_chg); end
            tests++; if (ctrl !== pack_ctrl()) begin fails++; $display("FAIL rand_ctrl[%0d]: got %h expected %h", n, ctrl, pack_ctrl()); end
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        reset          = 1'b1;
        bridge_addr    = 32'h0;
        bridge_wr      = 1'b0;
        bridge_rd      = 1'b0;
        bridge_wr_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            status_v[i] = 32'h0;
            m_ctrl[i]   = RST;
        end
        m_rd  = 32'h0;
        m_hit = 1'b0;
        m_chg = 4'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_write();
        test_status();
        test_miss();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_status_timing();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
